dec_mc: RTL
===========

DEC_MC -- requirements
Module: dec_mc

Interface
REQ-001 SHALL expose parameter NCH, default 4, number of independent decimation channels (1..16).
REQ-002 SHALL expose parameter CW, default 8, decimation-counter and ratio width in bits (4..16).
REQ-003 SHALL have one clock and an asynchronous, active-high reset; all state SHALL be in the SYSCLK domain.
REQ-004 SYSCLK  in  1  system clock, rising edge.
REQ-005 SYSRST  in  1  asynchronous, active-high reset.
REQ-006 sd_stb  in  NCH  per-channel modulator-bit strobe, one SYSCLK wide, already synchronised.
REQ-007 ch_en  in  NCH  per-channel enable.
REQ-008 ratio_wr  in  NCH  per-channel ratio load strobe.
REQ-009 ratio_in  in  CW  new decimation ratio minus one, shared by all channels.
REQ-010 sync_in  in  1  group restart pulse, present only when DEC_MC_SYNC_EN is defined.
REQ-011 osr  out  NCH  per-channel one-cycle decimation strobe.
REQ-012 cnt  out  NCH*CW  per-channel current count, channel k in bits [k*CW +: CW].
REQ-013 pend  out  NCH  per-channel flag: shadow ratio loaded, not yet active.

Function
REQ-014 Each channel SHALL hold an active ratio (act), a shadow ratio (shd) and a count, all CW bits wide.
REQ-015 Channel state: IDLE (ch_en=0) and RUN (ch_en=1); the transition SHALL occur on the first SYSCLK edge with the new ch_en value.
REQ-016 In IDLE: count SHALL be 0, osr SHALL be 0, and a pending shd SHALL be copied to act on the next edge, clearing pend.
REQ-017 In RUN, sd_stb=1 with count!=act: count SHALL increment by 1 on that edge.
REQ-018 In RUN, sd_stb=1 with count==act (terminal): count SHALL wrap to 0 and osr SHALL assert on the following cycle for exactly one cycle (latency 1 SYSCLK).
REQ-019 act=0 SHALL produce osr one cycle after every sd_stb; act=2^CW-1 SHALL produce osr every 2^CW strobes, with no arithmetic overflow.
REQ-020 ratio_wr=1 SHALL load ratio_in into shd and set pend on that edge; a second write before activation SHALL overwrite shd.
REQ-021 At a terminal event with pend=1: act SHALL take shd, pend SHALL clear, and the next period SHALL use the new ratio.
REQ-022 ratio_wr coincident with a terminal event: the written value SHALL go to shd and pend SHALL stay set; the prior shd (if any) SHALL become act.
REQ-023 The count SHALL never exceed act; act SHALL change only at a terminal event, in IDLE, or on sync.
REQ-024 sd_stb in IDLE SHALL be ignored.
REQ-025 A RUN-to-IDLE transition mid-period SHALL clear the count without asserting osr.

Reset
REQ-026 SYSRST=1 SHALL asynchronously force count=0, act=0, shd=0, pend=0, osr=0 on all channels.
REQ-027 Reset asserted mid-period SHALL discard the pending ratio and SHALL suppress any osr in flight.
REQ-028 The first osr after reset release SHALL require a full period of strobes.

Configuration
REQ-029 With DEC_MC_SYNC_EN defined, sync_in=1 SHALL, on that edge, clear every channel count to 0, copy any pending shd to act, clear pend, and suppress osr for terminal strobes in that cycle.
REQ-030 With DEC_MC_SYNC_EN defined, sync_in SHALL take priority over sd_stb and ratio_wr in the same cycle; ratio_wr SHALL still load shd and set pend afterwards.
REQ-031 Without DEC_MC_SYNC_EN, sync_in SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package dec_pkg SHALL hold the CW/NCH defaults, the channel-state enum (IDLE, RUN), and a helper that extracts the channel count slice.
REQ-033 Per-channel logic SHALL be one sub-module, dec_chan, instantiated NCH times by a generate loop; dec_mc SHALL contain only fan-out and sync distribution.

Verification
REQ-034 Verification SHALL cover ch_en=1, load 3, and 12 strobes: osr SHALL pulse 1 cycle after strobes 4, 8 and 12, with cnt sequence 1,2,3,0.
REQ-035 Verification SHALL cover act=3 and a write of 1 at count=2: pend=1 until the terminal strobe, then periods of 2 strobes and pend=0.
REQ-036 Verification SHALL cover ratio_wr coincident with the terminal strobe (shd=5, write 7): act=5 and shd=7 with pend=1 after the edge.
REQ-037 Verification SHALL cover act=255 with 256 strobes: exactly one osr, and cnt=0 afterwards.
REQ-038 Verification SHALL cover SYSRST pulse at count=2 of a ratio-3 channel with pend set: all outputs 0 and pend=0, and the first osr after 4 further strobes with act=0 -> 1 strobe.
REQ-039 With DEC_MC_SYNC_EN defined, verification SHALL cover 4 channels at differing counts and sync_in coincident with a channel-0 terminal strobe: all cnt=0, no osr, and aligned osr thereafter.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared types and defaults for the multi-channel decimation counter block.
package dec_pkg;

  localparam int NCH_DEF   = 4;
  localparam int CW_DEF    = 8;
  localparam int CNT_BUS_W = 256;  // widest count bus: 16 channels x 16 bits

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_st_t;

  // Returns channel k's count from a flattened count bus of cw-bit fields.
  function automatic logic [15:0] cnt_slice(input logic [CNT_BUS_W-1:0] bus,
                                            input int k, input int cw);
    logic [CNT_BUS_W-1:0] sh;
    sh = bus >> (k * cw);
    return sh[15:0] & 16'((32'd1 << cw) - 32'd1);
  endfunction

endpackage

// File: rtl/dec_mc_if.sv
// Bus bundle for dec_mc; sync_in exists only when DEC_MC_SYNC_EN is defined.
interface dec_mc_if
  import dec_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
);

  // No handshake: sd_stb, ratio_wr and sync_in are single-cycle strobes the
  // block always accepts; osr is a single-cycle strobe with no back-pressure.
  logic [NCH-1:0]    sd_stb;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ratio_wr;
  logic [CW-1:0]     ratio_in;
`ifdef DEC_MC_SYNC_EN
  logic              sync_in;
`endif
  logic [NCH-1:0]    osr;
  logic [NCH*CW-1:0] cnt;
  logic [NCH-1:0]    pend;
  logic [NCH-1:0]    run_st;

`ifdef DEC_MC_SYNC_EN
  modport master (output sd_stb, ch_en, ratio_wr, ratio_in, sync_in,
                  input  osr, cnt, pend, run_st);
  modport slave  (input  sd_stb, ch_en, ratio_wr, ratio_in, sync_in,
                  output osr, cnt, pend, run_st);
`else
  modport master (output sd_stb, ch_en, ratio_wr, ratio_in,
                  input  osr, cnt, pend, run_st);
  modport slave  (input  sd_stb, ch_en, ratio_wr, ratio_in,
                  output osr, cnt, pend, run_st);
`endif

endinterface

// File: rtl/dec_chan.sv
// One decimation channel: active/shadow ratio, strobe counter, registered osr.
module dec_chan
  import dec_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          SYSCLK,
  input  logic          SYSRST,
  input  logic          ch_en,
  input  logic          sd_stb,
  input  logic          ratio_wr,
  input  logic [CW-1:0] ratio_in,
  input  logic          sync,
  output logic          osr,
  output logic [CW-1:0] cnt,
  output logic          pend,
  output chan_st_t      st
);

  logic [CW-1:0] act;
  logic [CW-1:0] shd;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      st   <= IDLE;
      cnt  <= '0;
      act  <= '0;
      shd  <= '0;
      pend <= 1'b0;
      osr  <= 1'b0;
    end else begin
      st  <= ch_en ? RUN : IDLE;
      osr <= 1'b0;
      if (sync || !ch_en) begin
        cnt <= '0;
        if (pend) begin
          act  <= shd;
          pend <= 1'b0;
        end
      end else if (sd_stb) begin
        // Counting stops at act, so cnt+1 can never overflow.
        if (cnt == act) begin
          cnt <= '0;
          osr <= 1'b1;
          if (pend) begin
            act  <= shd;
            pend <= 1'b0;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // A write wins over the activation above; the old shadow still moves to act.
      if (ratio_wr) begin
        shd  <= ratio_in;
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_mc.sv
// Multi-channel decimation counter top: fans the bus out to NCH dec_chan
// instances. Optional group restart input guarded by DEC_MC_SYNC_EN.
module dec_mc
  import dec_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic     SYSCLK,
  input  logic     SYSRST,
  dec_mc_if.slave  bus
);

  logic              sync_w;
  logic [NCH-1:0]    osr_w;
  logic [NCH-1:0]    pend_w;
  logic [NCH-1:0]    run_w;
  logic [NCH*CW-1:0] cnt_w;
  chan_st_t          st_w [NCH];

`ifdef DEC_MC_SYNC_EN
  assign sync_w = bus.sync_in;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    dec_chan #(.CW(CW)) u_chan (
      .SYSCLK   (SYSCLK),
      .SYSRST   (SYSRST),
      .ch_en    (bus.ch_en[k]),
      .sd_stb   (bus.sd_stb[k]),
      .ratio_wr (bus.ratio_wr[k]),
      .ratio_in (bus.ratio_in),
      .sync     (sync_w),
      .osr      (osr_w[k]),
      .cnt      (cnt_w[k*CW +: CW]),
      .pend     (pend_w[k]),
      .st       (st_w[k])
    );
    assign run_w[k] = (st_w[k] == RUN);
  end

  assign bus.osr    = osr_w;
  assign bus.pend   = pend_w;
  assign bus.cnt    = cnt_w;
  assign bus.run_st = run_w;

endmodule
